// File: rtl/fifo_v3.sv
// Parameterisable synchronous FIFO with optional fall-through and a DEPTH=0 pass-through mode.
// Define FIFO_V3_ASSERT_EN to compile in simulation-only usage checks.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam int unsigned         FIFO_DEPTH = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_DEPTH:0]   CNT_ZERO = {(ADDR_DEPTH+1){1'b0}};
  localparam logic [ADDR_DEPTH:0]   CNT_ONE  = {{ADDR_DEPTH{1'b0}}, 1'b1};
  localparam logic [ADDR_DEPTH-1:0] PTR_ZERO = {ADDR_DEPTH{1'b0}};
  localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = {{(ADDR_DEPTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_DEPTH-1:0] PTR_LAST = ADDR_DEPTH'(FIFO_DEPTH - 32'd1);
  localparam dtype                  ZERO_ENTRY = dtype'({$bits(dtype){1'b0}});

  logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
  logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
  logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
  dtype                  mem_q [FIFO_DEPTH];
  dtype                  mem_d [FIFO_DEPTH];
  logic                  push_en_s, pop_en_s, ft_bypass_s;
  logic                  unused_testmode_s;

  assign unused_testmode_s = testmode_i;

  // Output decode; pass-through mode bypasses storage entirely.
  always_comb begin
    full_o  = (status_cnt_q == FULL_CNT);
    empty_o = (status_cnt_q == CNT_ZERO) && !(FALL_THROUGH && push_i);
    usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    data_o  = mem_q[read_ptr_q];
    if (DEPTH == 32'd0) begin
      data_o  = data_i;
      empty_o = ~push_i;
      full_o  = ~pop_i;
      usage_o = PTR_ZERO;
    end else if (FALL_THROUGH && (status_cnt_q == CNT_ZERO) && push_i) begin
      data_o = data_i;
    end else begin
      data_o = mem_q[read_ptr_q];
    end
  end

  // Next-state for pointers, fill count and memory.
  always_comb begin
    read_ptr_d   = read_ptr_q;
    write_ptr_d  = write_ptr_q;
    status_cnt_d = status_cnt_q;
    mem_d        = mem_q;
    // A fall-through push consumed in the same cycle never touches storage.
    ft_bypass_s  = FALL_THROUGH && (status_cnt_q == CNT_ZERO) && push_i && pop_i;
    push_en_s    = push_i && !full_o && (DEPTH != 32'd0) && !ft_bypass_s;
    pop_en_s     = pop_i && !empty_o && (DEPTH != 32'd0) && !ft_bypass_s;

    if (push_en_s) begin
      mem_d[write_ptr_q] = data_i;
      write_ptr_d = (write_ptr_q == PTR_LAST) ? PTR_ZERO : (write_ptr_q + PTR_ONE);
    end else begin
      write_ptr_d = write_ptr_q;
    end

    if (pop_en_s) begin
      read_ptr_d = (read_ptr_q == PTR_LAST) ? PTR_ZERO : (read_ptr_q + PTR_ONE);
    end else begin
      read_ptr_d = read_ptr_q;
    end

    case ({push_en_s, pop_en_s})
      2'b10:   status_cnt_d = status_cnt_q + CNT_ONE;
      2'b01:   status_cnt_d = status_cnt_q - CNT_ONE;
      default: status_cnt_d = status_cnt_q;
    endcase

    if (flush_i) begin
      read_ptr_d   = PTR_ZERO;
      write_ptr_d  = PTR_ZERO;
      status_cnt_d = CNT_ZERO;
    end else begin
      status_cnt_d = status_cnt_d;
    end
  end

  // State registers; reset clears memory as well as the bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_ptr_q   <= PTR_ZERO;
      write_ptr_q  <= PTR_ZERO;
      status_cnt_q <= CNT_ZERO;
      mem_q        <= '{default: ZERO_ENTRY};
    end else begin
      read_ptr_q   <= read_ptr_d;
      write_ptr_q  <= write_ptr_d;
      status_cnt_q <= status_cnt_d;
      mem_q        <= mem_d;
    end
  end

`ifdef FIFO_V3_ASSERT_EN
  if (DATA_WIDTH == 0) begin : g_width_check
    $fatal(1, "fifo_v3: DATA_WIDTH must be non-zero");
  end

  // Usage checks against the handshake rules.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push_i && full_o)) else $error("fifo_v3: push while full");
      assert (!(pop_i && empty_o)) else $error("fifo_v3: pop while empty");
    end else begin
    end
  end
`endif

endmodule

// File: tb/tb_fifo_v3.sv
// Scoreboard bench: three fifo_v3 configurations driven in lockstep, each with its own expected queue.
module tb_fifo_v3;
  typedef logic [7:0] byte_q_t [$];

  logic       clk_i = 1'b0;
  logic       rst_ni, flush_i, push_i, pop_i;
  logic [7:0] data_i;

  logic       full_a, empty_a, full_b, empty_b, full_c, empty_c;
  logic [1:0] usage_a, usage_b, usage_c;
  logic [7:0] dout_a, dout_b, dout_c;

  int      n_checks = 0;
  int      n_fail   = 0;
  byte_q_t q_a, q_b, q_c;

  always #5 clk_i = ~clk_i;

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_d4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .testmode_i(1'b0),
    .full_o(full_a), .empty_o(empty_a), .usage_o(usage_a),
    .data_i(data_i), .push_i(push_i), .data_o(dout_a), .pop_i(pop_i));

  fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_ft (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .testmode_i(1'b0),
    .full_o(full_b), .empty_o(empty_b), .usage_o(usage_b),
    .data_i(data_i), .push_i(push_i), .data_o(dout_b), .pop_i(pop_i));

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .testmode_i(1'b0),
    .full_o(full_c), .empty_o(empty_c), .usage_o(usage_c),
    .data_i(data_i), .push_i(push_i), .data_o(dout_c), .pop_i(pop_i));

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare one instance's outputs with its queue, then advance the queue as the edge will.
  task automatic eval_inst(input string tag, input int depth, input bit ft,
                           input logic [7:0] dout, input logic full, input logic empty,
                           input logic [1:0] usage, input bit push, input bit pop,
                           input logic [7:0] din, input bit flush, inout byte_q_t q);
    int cnt;
    bit exp_empty, exp_full;
    cnt       = q.size();
    exp_full  = (cnt == depth);
    exp_empty = (cnt == 0) && !(ft && push);
    check_value({tag, "_full"},  {31'd0, full},  {31'd0, exp_full});
    check_value({tag, "_empty"}, {31'd0, empty}, {31'd0, exp_empty});
    check_value({tag, "_usage"}, {30'd0, usage}, {30'd0, 2'(cnt)});
    if (ft && cnt == 0 && push) check_value({tag, "_ftdata"}, {24'd0, dout}, {24'd0, din});
    else if (cnt > 0)           check_value({tag, "_data"},   {24'd0, dout}, {24'd0, q[0]});
    if (flush) begin
      q.delete();
    end else if (!(ft && cnt == 0 && push && pop)) begin
      if (pop && !exp_empty) void'(q.pop_front());
      if (push && !exp_full) q.push_back(din);
    end
  endtask

  task automatic step(input bit push, input bit pop, input logic [7:0] din, input bit flush);
    push_i = push; pop_i = pop; data_i = din; flush_i = flush;
    #2;
    eval_inst("d4", 4, 1'b0, dout_a, full_a, empty_a, usage_a, push, pop, din, flush, q_a);
    eval_inst("ft", 4, 1'b1, dout_b, full_b, empty_b, usage_b, push, pop, din, flush, q_b);
    eval_inst("d3", 3, 1'b0, dout_c, full_c, empty_c, usage_c, push, pop, din, flush, q_c);
    @(posedge clk_i);
    #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_value({tag, "_d4_rst"}, {dout_a, 6'd0, usage_a, 6'd0, full_a, empty_a}, 32'h0000_0001);
    check_value({tag, "_ft_rst"}, {dout_b, 6'd0, usage_b, 6'd0, full_b, empty_b}, 32'h0000_0001);
    check_value({tag, "_d3_rst"}, {dout_c, 6'd0, usage_c, 6'd0, full_c, empty_c}, 32'h0000_0001);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; data_i = 8'h00;
    #1;
    check_reset("init");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Fill to full, then push+pop while full, then drain.
    step(1'b1, 1'b0, 8'h0A, 1'b0);
    step(1'b1, 1'b0, 8'h0B, 1'b0);
    step(1'b1, 1'b0, 8'h0C, 1'b0);
    step(1'b1, 1'b0, 8'h0D, 1'b0);
    step(1'b1, 1'b1, 8'h0E, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Empty push+pop: zero-latency consume in fall-through, a plain push otherwise.
    step(1'b1, 1'b1, 8'h05, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic exercises pointer wrap on the depth-3 instance.
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0), 8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Flush beats a simultaneous push.
    step(1'b1, 1'b0, 8'h21, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h23, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset in the middle of a burst.
    step(1'b1, 1'b0, 8'h31, 1'b0);
    step(1'b1, 1'b0, 8'h32, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset("mid");
    q_a.delete(); q_b.delete(); q_c.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
